// File: rtl/icache_l1_pkg.sv
// Shared definitions for the L1 instruction cache, the L2 instruction cache
// and the fetch stage: geometry, derived tag width, controller state encoding
// and a helper that picks one instruction word out of a 128-bit line.
package icache_l1_pkg;

  localparam int NUM_OF_LINE = 8;
  localparam int LINE_OFFSET = 3;
  localparam int TAG_W       = 28 - LINE_OFFSET;
  localparam int LINE_W      = 128;
  localparam int WORD_W      = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Word w of a line occupies bits [32w+31:32w].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        w);
    return line[{w, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_l1_perf.sv
// Hit / miss performance counters for the L1 instruction cache.
// Both counters stop at 16'hFFFF instead of wrapping.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   hit_inc, miss_inc   one-cycle increment enables
//   hit_cnt, miss_cnt   saturating counts
module icache_l1_perf
  import icache_l1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
      if (miss_inc && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped, read-only L1 instruction cache.
// Hits complete combinationally in IDLE; a miss latches {tag,index}, then
// requests the whole 128-bit line from L2 and refills it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | serving fetches; hit returns a word the same cycle, miss -> REQ
// REQ   | mem_read held with latched line address until mem_ready
//
// Ports:
//   clk, proc_reset              clock, asynchronous active-high reset
//   proc_read, proc_addr         fetch request and 30-bit word address
//   proc_rdata, proc_stall       fetched word, fetch-not-complete flag
//   mem_read, mem_addr           line request to L2 (mem_addr[1:0] = 0)
//   mem_rdata, mem_ready         line data and valid strobe from L2
//   hit_cnt, miss_cnt            saturating performance counters
module icache_l1
  import icache_l1_pkg::*;
#(
  parameter int NUM_OF_LINE = icache_l1_pkg::NUM_OF_LINE,
  parameter int LINE_OFFSET = icache_l1_pkg::LINE_OFFSET
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic [29:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [29:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
);

  localparam int TW = 28 - LINE_OFFSET;

  state_t                 state_q, state_d;
  logic [127:0]           data_q [NUM_OF_LINE];
  logic [TW-1:0]          tag_q  [NUM_OF_LINE];
  logic [NUM_OF_LINE-1:0] valid_q;
  logic [27:0]            miss_addr_q;   // {tag, index} of the outstanding miss

  logic [TW-1:0]          req_tag;
  logic [LINE_OFFSET-1:0] req_idx;
  logic [TW-1:0]          fill_tag;
  logic [LINE_OFFSET-1:0] fill_idx;
  logic                   hit;
  logic                   hit_inc, miss_inc, miss_load, fill;

  assign req_tag  = proc_addr[29:2+LINE_OFFSET];
  assign req_idx  = proc_addr[1+LINE_OFFSET:2];
  assign fill_tag = miss_addr_q[27:LINE_OFFSET];
  assign fill_idx = miss_addr_q[LINE_OFFSET-1:0];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    miss_load  = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (proc_read) begin
          if (hit) begin
            proc_rdata = line_word(data_q[req_idx], proc_addr[1:0]);
            hit_inc    = 1'b1;
          end else begin
            // Request goes out from REQ next cycle so mem_addr comes from a register.
            proc_stall = 1'b1;
            miss_inc   = 1'b1;
            miss_load  = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        // Processor inputs are ignored here: the fill always completes for
        // the latched address, and the refetch in IDLE decides what happens next.
        mem_read   = 1'b1;
        mem_addr   = {miss_addr_q, 2'b00};
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      for (int i = 0; i < NUM_OF_LINE; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss_load)
        miss_addr_q <= proc_addr[29:2];
      if (fill) begin
        data_q[fill_idx]  <= mem_rdata;
        tag_q[fill_idx]   <= fill_tag;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  icache_l1_perf u_perf (
    .clk      (clk),
    .rst      (proc_reset),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: inputs change on the falling edge and
// outputs are sampled 1 ns later, well before the next rising edge.
module tb_icache_l1;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [29:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B = 128'hBBBB_0003_BBBB_0002_BBBB_0001_BBBB_0000;
  localparam logic [127:0] LINE_C = 128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000;
  localparam logic [127:0] LINE_D = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
  localparam logic [127:0] LINE_E = 128'hEEEE_0003_EEEE_0002_EEEE_0001_EEEE_0000;
  localparam logic [127:0] LINE_F = 128'hFFFF_0003_FFFF_0002_FFFF_0001_FFFF_0000;
  localparam logic [127:0] JUNK   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  icache_l1 dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    proc_read  = 1'b0;
    mem_ready  = 1'b0;
    proc_reset = 1'b1;
    #2;
    proc_reset = 1'b0;
  endtask

  // Miss with L2 answering in the first REQ cycle, then the refetch hit.
  task automatic miss_fill(input logic [29:0] addr, input logic [127:0] line,
                           input logic [29:0] exp_maddr, input logic [31:0] exp_word,
                           input string name);
    @(negedge clk);
    proc_read = 1'b1; proc_addr = addr; mem_ready = 1'b0; mem_rdata = JUNK;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_detect: stall=%b mem_read=%b, required stall=1 mem_read=0",
               name, proc_stall, mem_read);
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = line;
    #1;
    n_cmp++;
    if (mem_read !== 1'b1 || mem_addr !== exp_maddr || proc_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_req: mem_read=%b mem_addr=%h stall=%b, required 1 %h 1",
               name, mem_read, mem_addr, proc_stall, exp_maddr);
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = JUNK;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== exp_word) begin
      n_bad++;
      $display("FAIL %s_rehit: stall=%b rdata=%h, required stall=0 rdata=%h",
               name, proc_stall, proc_rdata, exp_word);
    end
  endtask

  task automatic check_counts(input logic [15:0] exp_hit, input logic [15:0] exp_miss,
                              input string name);
    @(negedge clk);
    proc_read = 1'b0;
    #1;
    n_cmp++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      n_bad++;
      $display("FAIL %s_counts: hit=%h miss=%h, required hit=%h miss=%h",
               name, hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1; proc_read = 1'b0; proc_addr = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 30'h0 ||
        proc_rdata !== 32'h0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state: stall=%b mem_read=%b mem_addr=%h rdata=%h hit=%h miss=%h, required all 0",
               proc_stall, mem_read, mem_addr, proc_rdata, hit_cnt, miss_cnt);
    end
    proc_reset = 1'b0;
  endtask

  task automatic test_first_miss();
    miss_fill(30'h10, LINE_A, 30'h10, 32'h1111_1111, "first");
    @(negedge clk);
    proc_read = 1'b0; proc_addr = 30'h10;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL no_read_idle: stall=%b rdata=%h, required 0 0", proc_stall, proc_rdata);
    end
    n_cmp++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL first_counts: hit=%h miss=%h, required 1 1", hit_cnt, miss_cnt);
    end
    check_counts(16'd1, 16'd1, "idle_no_change");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333; exp_w[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      proc_read = 1'b1; proc_addr = 30'h10 + 30'(i);
      #1;
      n_cmp++;
      if (proc_stall !== 1'b0 || proc_rdata !== exp_w[i] || mem_read !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_hit_%0d: stall=%b rdata=%h mem_read=%b, required 0 %h 0",
                 i, proc_stall, proc_rdata, mem_read, exp_w[i]);
      end
    end
    check_counts(16'd5, 16'd1, "seq");
  endtask

  task automatic test_conflict();
    apply_reset();
    miss_fill(30'h10, LINE_A, 30'h10, 32'h1111_1111, "conf_a");
    miss_fill(30'h30, LINE_B, 30'h30, 32'hBBBB_0000, "conf_b");
    miss_fill(30'h10, LINE_C, 30'h10, 32'hCCCC_0000, "conf_c");
    check_counts(16'd3, 16'd3, "conf");
  endtask

  task automatic test_late_ready();
    apply_reset();
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h10; mem_ready = 1'b0; mem_rdata = JUNK;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL late_detect: stall=%b mem_read=%b, required 1 0", proc_stall, mem_read);
    end
    // Five REQ cycles without mem_ready, then ready; processor wanders meanwhile.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      proc_addr = 30'h50;
      proc_read = (k % 2 == 0);
      mem_ready = (k == 5);
      mem_rdata = (k == 5) ? LINE_D : JUNK;
      #1;
      n_cmp++;
      if (mem_read !== 1'b1 || mem_addr !== 30'h10 || proc_stall !== 1'b1) begin
        n_bad++;
        $display("FAIL late_req_%0d: mem_read=%b mem_addr=%h stall=%b, required 1 00000010 1",
                 k, mem_read, mem_addr, proc_stall);
      end
    end
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h13; mem_ready = 1'b0; mem_rdata = JUNK;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hDDDD_0003) begin
      n_bad++;
      $display("FAIL late_line_written: stall=%b rdata=%h, required 0 dddd0003", proc_stall, proc_rdata);
    end
    miss_fill(30'h50, LINE_E, 30'h50, 32'hEEEE_0000, "late_50");
    check_counts(16'd2, 16'd2, "late");
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h10; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_pre: mem_read=%b, required 1", mem_read);
    end
    proc_read  = 1'b0;
    proc_reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || mem_addr !== 30'h0 || proc_stall !== 1'b0 ||
        hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_mid_async: mem_read=%b mem_addr=%h stall=%b hit=%h miss=%h, required all 0",
               mem_read, mem_addr, proc_stall, hit_cnt, miss_cnt);
    end
    proc_reset = 1'b0;
    // 0x50 was resident before the reset; it must miss now.
    miss_fill(30'h50, LINE_F, 30'h50, 32'hFFFF_0000, "rst_refetch");
    check_counts(16'd1, 16'd1, "rst_mid");
  endtask

  task automatic test_saturate();
    @(negedge clk);
    proc_read = 1'b0;
    force dut.u_perf.hit_cnt = 16'hFFFE;
    #1;
    release dut.u_perf.hit_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      proc_read = 1'b1; proc_addr = 30'h51 + 30'(i);
      #1;
      n_cmp++;
      if (proc_stall !== 1'b0 || proc_rdata !== (i == 0 ? 32'hFFFF_0001 : 32'hFFFF_0002)) begin
        n_bad++;
        $display("FAIL sat_hit_%0d: stall=%b rdata=%h, required stall=0", i, proc_stall, proc_rdata);
      end
    end
    check_counts(16'hFFFF, 16'd1, "sat");
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_sequential();
    test_conflict();
    test_late_ready();
    test_reset_mid_req();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
